// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared definitions for the instruction fetch unit: FSM state
//            encoding, instruction width, NOP word, default reset PC and
//            small PC helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Instruction and address widths
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Bubble word presented to Decode when IF/ID holds no real instruction
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // First fetch address after reset
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word alignment mask applied to redirect targets
    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch FSM states
    //   ST_REQ  : imem_req may be asserted with imem_addr = PC
    //   ST_WAIT : one request granted, waiting for its rvalid
    //   ST_HOLD : returned word parked in the buffer while Decode stalls
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Sequential next PC, wrapping naturally at 2^32
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : One-entry buffer holding a returned instruction word and its
//            PC+4 while Decode is stalled.
// Ports    : clk, rst_n          - clock, async active-low reset
//            load                - capture load_word / load_pc_plus4
//            drain               - entry consumed by IF/ID
//            clear               - discard entry (redirect); highest priority
//            load_word           - instruction word to park
//            load_pc_plus4       - PC+4 belonging to load_word
//            valid               - buffer holds a word
//            word, pc_plus4      - buffered contents
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_word,
    input  logic [ADDR_W-1:0]  load_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] word,
    output logic [ADDR_W-1:0]  pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            word     <= NOP_WORD;
            pc_plus4 <= '0;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            word     <= load_word;
            pc_plus4 <= load_pc_plus4;
        end else if (drain) begin
            valid    <= 1'b0;
        end
    end

endmodule : fetch_buffer
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with a single outstanding request to
//            instruction memory, a one-word stall buffer, redirect handling
//            with response swallowing, and the IF/ID pipeline register.
// Config   : FETCH_DELAY_SLOT_EN - when defined, a redirect keeps the IF/ID
//            contents (branch delay slot); otherwise a redirect flushes IF/ID,
//            overriding stall.
// Ports    : clk, rst_n          - clock, async active-low reset
//            stall               - hold PC and IF/ID
//            redirect            - one-cycle taken-branch pulse
//            redirect_pc         - redirect target (low 2 bits ignored)
//            imem_req/imem_addr  - memory read request and word address
//            imem_gnt            - request accepted this cycle
//            imem_rvalid/rdata   - returned instruction word
//            Instruction         - IF/ID instruction
//            PC_plus4            - IF/ID PC+4
//            if_valid            - IF/ID holds a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  PC_plus4,
    output logic               if_valid
);

    fetch_state_t       state;
    fetch_state_t       state_d;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_d;
    logic               kill;
    logic               kill_d;
    logic               req_q;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  pc4_q;
    logic [ADDR_W-1:0]  pc4_d;
    logic               valid_q;
    logic               valid_d;

    logic               accept;
    logic               word_in;
    logic               pending_after_redirect;
    logic [ADDR_W-1:0]  redirect_target;
    logic               buf_load;
    logic               buf_drain;
    logic               buf_clear;
    logic               direct_load;
    logic               buf_valid;
    logic [INSTR_W-1:0] buf_word;
    logic [ADDR_W-1:0]  buf_pc4;

    // A grant only counts while the request is actually presented
    assign accept  = req_q & imem_gnt;

    // The kill flag can only be set while in ST_REQ, so a response seen in
    // ST_WAIT always belongs to the live request
    assign word_in = (state == ST_WAIT) & imem_rvalid;

    assign redirect_target = redirect_pc & PC_ALIGN_MASK;

    // After a redirect, a response is still owed to us if a request was
    // outstanding and its data is not arriving this very cycle, if a request
    // is being granted right now, or if an earlier kill is still pending
    assign pending_after_redirect = ((state == ST_WAIT) & ~imem_rvalid)
                                  | accept
                                  | (kill & ~imem_rvalid);

    assign buf_clear   = redirect;
    assign buf_load    = ~redirect & word_in & stall;
    assign buf_drain   = ~redirect & (state == ST_HOLD) & buf_valid & ~stall;
    assign direct_load = ~redirect & word_in & ~stall;

    fetch_buffer u_fetch_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (buf_load),
        .drain         (buf_drain),
        .clear         (buf_clear),
        .load_word     (imem_rdata),
        .load_pc_plus4 (pc),
        .valid         (buf_valid),
        .word          (buf_word),
        .pc_plus4      (buf_pc4)
    );

    // ------------------------------------------------------------------
    // Next-state, PC and kill flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        pc_d    = pc;
        kill_d  = kill;
        if (redirect) begin
            state_d = ST_REQ;
            pc_d    = redirect_target;
            kill_d  = pending_after_redirect;
        end else begin
            case (state)
                ST_REQ: begin
                    if (kill) begin
                        // Swallow the response of a discarded request
                        if (imem_rvalid) begin
                            kill_d = 1'b0;
                        end
                    end else if (accept) begin
                        state_d = ST_WAIT;
                        pc_d    = pc_inc(pc);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = stall ? ST_HOLD : ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (buf_drain) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID next value
    // ------------------------------------------------------------------
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            // Delay slot: the instruction already in IF/ID proceeds
            instr_d = instr_q;
            valid_d = valid_q;
`else
            // Flush wins over stall
            instr_d = NOP_WORD;
            valid_d = 1'b0;
`endif
        end else if (!stall) begin
            if (direct_load) begin
                // pc already advanced on grant, so it equals fetched PC+4
                instr_d = imem_rdata;
                pc4_d   = pc;
                valid_d = 1'b1;
            end else if (buf_drain) begin
                instr_d = buf_word;
                pc4_d   = buf_pc4;
                valid_d = 1'b1;
            end else begin
                // Decode consumed the previous word and nothing new arrived
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers; imem_req is registered from the next state so that
    // it is low during reset and rises in the first clock after release
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_REQ;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            req_q   <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            kill    <= kill_d;
            req_q   <= (state_d == ST_REQ) & ~kill_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign Instruction = instr_q;
    assign PC_plus4    = pc4_q;
    assign if_valid    = valid_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: a directed vector table for
//            the key fetch/stall/redirect/wrap sequences, an asynchronous
//            reset check, and randomized traffic compared against a
//            queue-based reference model of the fetch rules.
// Config   : FETCH_DELAY_SLOT_EN - expected IF/ID behaviour on redirect
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instruction;
    logic [31:0] PC_plus4;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC_plus4    (PC_plus4),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic [31:0] einstr, input logic [31:0] epc4, input logic evalid);
        chk({tag, ".imem_req"},    {31'd0, imem_req}, {31'd0, ereq});
        chk({tag, ".imem_addr"},   imem_addr,         eaddr);
        chk({tag, ".Instruction"}, Instruction,       einstr);
        chk({tag, ".PC_plus4"},    PC_plus4,          epc4);
        chk({tag, ".if_valid"},    {31'd0, if_valid}, {31'd0, evalid});
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic g, input logic rv, input logic [31:0] rdat);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rdat;
    endtask

    // ------------------------------------------------------------------
    // Reference model: outstanding responses and the stall buffer as queues
    // ------------------------------------------------------------------
    typedef struct { bit killed; logic [31:0] pc4; } pend_t;
    typedef struct { logic [31:0] w; logic [31:0] pc4; } bent_t;
    pend_t       pend[$];
    bent_t       bufq[$];
    logic [31:0] m_pc;
    logic        m_req;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    task automatic model_reset();
        pend.delete();
        bufq.delete();
        m_pc    = 32'h0;
        m_req   = 1'b0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit g, input bit rv, input logic [31:0] rdat);
        bit          grant;
        bit          have_word;
        bit          had_buf;
        logic [31:0] w;
        logic [31:0] wpc4;
        pend_t       e;
        bent_t       b;
        grant     = m_req && g;
        have_word = 1'b0;
        had_buf   = (bufq.size() > 0);
        w         = '0;
        wpc4      = '0;
        if (rv && pend.size() > 0) begin
            e = pend.pop_front();
            if (!e.killed && !rd) begin
                have_word = 1'b1;
                w         = rdat;
                wpc4      = e.pc4;
            end
        end
        if (rd) begin
            foreach (pend[i]) pend[i].killed = 1'b1;
            if (grant) pend.push_back('{1'b1, m_pc + 32'd4});
            bufq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (!DS) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
        end else begin
            if (grant) begin
                pend.push_back('{1'b0, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
            if (st) begin
                if (have_word) bufq.push_back('{w, wpc4});
            end else if (have_word) begin
                m_instr = w;
                m_pc4   = wpc4;
                m_valid = 1'b1;
            end else if (had_buf) begin
                b       = bufq.pop_front();
                m_instr = b.w;
                m_pc4   = b.pc4;
                m_valid = 1'b1;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
        end
        m_req = (pend.size() == 0) && (bufq.size() == 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, outputs after the edge
    // ------------------------------------------------------------------
    typedef struct {
        logic        st, rd;
        logic [31:0] rpc;
        logic        g, rv;
        logic [31:0] rdat;
        logic        ereq;
        logic [31:0] eaddr, einstr, epc4;
        logic        evalid;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic g, input logic rv, input logic [31:0] rdat,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic [31:0] einstr, input logic [31:0] epc4,
                                input logic evalid);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.g = g; v.rv = rv; v.rdat = rdat;
        v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.epc4 = epc4; v.evalid = evalid;
        return v;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        //       st rd rpc           g  rv rdata          req addr          instr                      pc4           valid
        tbl[0]  = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h0,        32'h0,                     32'h0,        0);
        tbl[1]  = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h4,        32'h0,                     32'h0,        0);
        tbl[2]  = mk(0, 0, 32'h0,       0, 1, 32'h2008_0005,1, 32'h4,        32'h2008_0005,             32'h4,        1);
        tbl[3]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,        32'h2008_0005,             32'h4,        1);
        tbl[4]  = mk(1, 0, 32'h0,       0, 1, 32'h0109_4820,0, 32'h8,        32'h2008_0005,             32'h4,        1);
        tbl[5]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,        32'h2008_0005,             32'h4,        1);
        tbl[6]  = mk(1, 0, 32'h0,       0, 0, 32'h0,        0, 32'h8,        32'h2008_0005,             32'h4,        1);
        tbl[7]  = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h8,        32'h0109_4820,             32'h8,        1);
        tbl[8]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'hC,        32'h0109_4820,             32'h8,        1);
        tbl[9]  = mk(0, 1, 32'h40,      0, 0, 32'h0,        0, 32'h40,       DS ? 32'h0109_4820 : 32'h0, 32'h8,        DS);
        tbl[10] = mk(0, 0, 32'h0,       0, 1, 32'hDEAD_BEEF,1, 32'h40,       32'h0,                     32'h8,        0);
        tbl[11] = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h44,       32'h0,                     32'h8,        0);
        tbl[12] = mk(0, 0, 32'h0,       0, 1, 32'h1234_5678,1, 32'h44,       32'h1234_5678,             32'h44,       1);
        tbl[13] = mk(0, 1, 32'hFFFF_FFFF,0, 0, 32'h0,       1, 32'hFFFF_FFFC,DS ? 32'h1234_5678 : 32'h0, 32'h44,       DS);
        tbl[14] = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h0,        32'h0,                     32'h44,       0);
        tbl[15] = mk(0, 0, 32'h0,       0, 1, 32'hAAAA_5555,1, 32'h0,        32'hAAAA_5555,             32'h0,        1);
        tbl[16] = mk(0, 1, 32'h13,      1, 0, 32'h0,        0, 32'h10,       DS ? 32'hAAAA_5555 : 32'h0, 32'h0,        DS);
        tbl[17] = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h10,       32'h0,                     32'h0,        0);
        tbl[18] = mk(0, 0, 32'h0,       0, 1, 32'hBAD0_BAD0,1, 32'h10,       32'h0,                     32'h0,        0);
        tbl[19] = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h14,       32'h0,                     32'h0,        0);
        tbl[20] = mk(0, 0, 32'h0,       0, 1, 32'h8C42_0004,1, 32'h14,       32'h8C42_0004,             32'h14,       1);
        tbl[21] = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h18,       32'h8C42_0004,             32'h14,       1);

        // Outputs while reset is held from time zero
        #3;
        chk_all("por", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        reset_dut();
        // Released at a negedge: request not yet presented
        chk("post_release.imem_req", {31'd0, imem_req}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].g, tbl[i].rv, tbl[i].rdat);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr,
                    tbl[i].einstr, tbl[i].epc4, tbl[i].evalid);
        end

        // Asynchronous reset in the middle of a WAIT cycle
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Late response for the pre-reset request must be ignored in REQ
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk_all("after_rst", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            bit          st, rd, g, rv;
            logic [31:0] rpc, rdat;
            chk_all($sformatf("rnd%0d", n), m_req, m_pc, m_instr, m_pc4, m_valid);
            st   = ($urandom_range(0, 3) == 0);
            rd   = ($urandom_range(0, 15) == 0);
            rpc  = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            g    = ($urandom_range(0, 1) == 1);
            rv   = (pend.size() > 0) ? ($urandom_range(0, 2) == 0)
                                     : ($urandom_range(0, 19) == 0);
            rdat = $urandom;
            model_step(st, rd, rpc, g, rv, rdat);
            drive(st, rd, rpc, g, rv, rdat);
            @(negedge clk);
        end
        chk_all("rnd_end", m_req, m_pc, m_instr, m_pc4, m_valid);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hazard hold: keep PC and IF/ID register unchanged.
REQ-005 redirect  input  1  taken branch/J/JR resolved downstream; one-cycle pulse.
REQ-006 redirect_pc  input  32  target address, valid when redirect=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  word address of request, stable while imem_req=1.
REQ-009 imem_gnt  input  1  request accepted this cycle (imem_req&imem_gnt).
REQ-010 imem_rvalid  input  1  read data returned; at least 1 cycle after grant.
REQ-011 imem_rdata  input  32  returned instruction word.
REQ-012 Instruction  output  32  IF/ID instruction to Decode.
REQ-013 PC_plus4  output  32  IF/ID PC+4 of Instruction.
REQ-014 if_valid  output  1  IF/ID holds a real instruction.

Function
REQ-015 Block SHALL allow at most one outstanding imem request.
REQ-016 FSM states: REQ (imem_req=1, imem_addr=PC), WAIT (await rvalid), HOLD (word buffered, stall=1).
REQ-017 REQ: on gnt -> WAIT, PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); no gnt -> stay REQ.
REQ-018 WAIT: on rvalid, stall=0 -> load IF/ID (Instruction=rdata, PC_plus4=fetched PC+4, if_valid=1), -> REQ.
REQ-019 WAIT: on rvalid, stall=1 -> capture rdata in a one-word buffer, -> HOLD; if_valid and IF/ID unchanged.
REQ-020 HOLD: when stall=0 -> load IF/ID from buffer, -> REQ; imem_req=0 throughout HOLD.
REQ-021 In REQ with stall=0 and no word to load, if_valid SHALL drop to 0 and Instruction SHALL become 32'h0000_0000 (bubble).
REQ-022 stall=1 SHALL freeze Instruction, PC_plus4, if_valid; fetch progresses only into the buffer.
REQ-023 redirect=1 SHALL set PC <= redirect_pc, discard any outstanding or buffered word, and next cycle -> REQ.
REQ-024 Response to a discarded request SHALL be swallowed: an internal kill flag stays set until its rvalid, then clears; no new request until then.
REQ-025 redirect in REQ with gnt the same cycle: granted request is discarded per REQ-024; PC = redirect_pc.
REQ-026 redirect and stall both 1: redirect wins for PC and discard; IF/ID handling per REQ-036/037.
REQ-027 redirect_pc low 2 bits SHALL be forced to 00.
REQ-028 Fetch latency: rvalid in cycle N with stall=0 -> Instruction valid in cycle N+1.

Reset
REQ-029 rst_n=0 SHALL asynchronously set PC=RESET_PC, FSM=REQ, kill flag=0, buffer empty.
REQ-030 During reset: Instruction=0, PC_plus4=0, if_valid=0, imem_req=0.
REQ-031 First imem_req SHALL assert in first clock after rst_n deasserts, addr=RESET_PC.
REQ-032 rvalid arriving after reset for a pre-reset request SHALL be ignored if the FSM is in REQ.

Configuration
REQ-033 Macro FETCH_DELAY_SLOT_EN selects MIPS branch-delay-slot semantics.
REQ-034 Defined: redirect SHALL NOT flush IF/ID; the instruction in IF/ID (delay slot) proceeds.
REQ-035 Undefined: redirect SHALL flush IF/ID next edge (Instruction=0, if_valid=0).
REQ-036 With macro and stall=1 on redirect: IF/ID held.
REQ-037 Without macro: flush overrides stall.

Structure
REQ-038 Shared package SHALL hold: FSM state encoding, NOP word (32'h0), RESET_PC default, instruction width 32.
REQ-039 One sub-module: fetch_buffer (one-entry word buffer with PC_plus4, load/drain/clear).
REQ-040 No combinational path from imem_rdata to Instruction.

Verification
REQ-041 Reset release, gnt same cycle, rvalid 1 cycle later, rdata=32'h2008_0005 -> imem_addr=0, Instruction=32'h2008_0005, PC_plus4=4 two cycles after gnt.
REQ-042 stall=1 when rvalid with rdata=32'h0109_4820, 3 cycles -> IF/ID unchanged, imem_req=0; stall drop -> Instruction=32'h0109_4820 next cycle.
REQ-043 redirect to 32'h0000_0040 while WAIT at PC 8 -> stale rdata dropped; next imem_addr=32'h40; without macro if_valid=0 next cycle.
REQ-044 Same as REQ-043 with FETCH_DELAY_SLOT_EN -> IF/ID instruction kept, if_valid stays 1.
REQ-045 PC 32'hFFFF_FFFC granted -> next imem_addr=0; redirect_pc=32'h0000_0013 -> imem_addr=32'h10.
REQ-046 rst_n low mid-WAIT -> outputs zero asynchronously; after release imem_addr=RESET_PC.
